data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder_pkg.sv | 52 +++++
 rtl/data_bus_responder_if.sv | 28 ++
 rtl/data_bus_responder_key_capture.sv | 45 ++++
 rtl/data_bus_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_bus_responder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data bus responder.
//   - req_ctrl size/sign encoding (funct3 style)
//   - MMIO register addresses
//   - responder FSM state encoding
//   - load_extend(): lane select + sign/zero extension of a loaded word
package bus_pkg;

    localparam int NUM_KEYS = 4;
    localparam int NUM_SW   = 10;

    typedef enum logic [2:0] {
        CTRL_B  = 3'b000,
        CTRL_H  = 3'b001,
        CTRL_W  = 3'b010,
        CTRL_BU = 3'b100,
        CTRL_HU = 3'b101
    } ctrl_e;

    localparam logic [31:0] ADDR_HEX    = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEDR   = 32'h1000_0004;
    localparam logic [31:0] ADDR_SW     = 32'h1000_0008;
    localparam logic [31:0] ADDR_KEYCAP = 32'h1000_000C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Pick the addressed byte/halfword out of a full word and extend it.
    // Word accesses pass through untouched.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  ctrl);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? word[31:16] : word[15:0];
        case (ctrl)
            CTRL_B:  r = {{24{b[7]}}, b};
            CTRL_BU: r = {24'h0, b};
            CTRL_H:  r = {{16{h[15]}}, h};
            CTRL_HU: r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Processor <-> responder load/store bus.
//   master: processor side (drives request, consumes response)
//   slave : responder side (accepts request, produces response)
interface data_bus_if;
    import bus_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_ctrl, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_ctrl, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_bus_responder_key_capture.sv
// Key press capture.
//   key_in   : raw active-low keys (asynchronous)
//   clr_i    : per-key clear strobe (write-1-to-clear from the bus)
//   keycap_o : sticky "key was pressed" flags
// Keys are synchronized through two flops, then a press is a 1->0 step
// of the synchronized value. A press arriving with a clear keeps the bit set.
module key_capture
    import bus_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] clr_i,
    output logic [NUM_KEYS-1:0] keycap_o
);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_KEYS-1:0] keycap_q, keycap_d;
    logic [NUM_KEYS-1:0] fall;

    // Released keys read high, so the pipeline resets to 1 to avoid a
    // phantom press straight out of reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            prev_q   <= '1;
            keycap_q <= '0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            keycap_q <= keycap_d;
        end
    end

    assign fall = prev_q & ~sync2_q;

    always_comb begin
        keycap_d = (keycap_q & ~clr_i) | fall;
    end

    assign keycap_o = keycap_q;

endmodule

// File: rtl/data_bus_responder.sv
// Load/store responder: on-chip data RAM plus board MMIO.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : data_bus_if slave (request/response handshake)
//   sw_in        : board switches (async)
//   key_in       : board keys (async, active-low)
//   hex_value    : six 7-segment digit value register
//   ledr_out     : LED register
// One request in flight: IDLE accepts, ACCESS does the RAM read / commits
// stores, RESP holds the response until the processor takes it.
module data_bus_responder
    import bus_pkg::*;
#(
    parameter int RAM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    data_bus_if.slave         bus,
    input  logic [NUM_SW-1:0] sw_in,
    input  logic [3:0]        key_in,
    output logic [23:0]       hex_value,
    output logic [9:0]        ledr_out
);

    localparam int AW = $clog2(RAM_WORDS);

    state_e state_q, state_d;

    // latched request
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ctrl_q;

    // latched access result, held through RESP
    logic        err_q;
    logic        is_ram_q;
    logic [31:0] mmio_word_q;
    logic [31:0] ram_rdata_q;

    logic [23:0]       hex_q;
    logic [9:0]        ledr_q;
    logic [NUM_SW-1:0] sw_s1_q, sw_s2_q;
    logic [3:0]        keycap;
    logic [3:0]        keycap_clr;

    // ---------------- decode of the latched request ----------------
    logic in_ram, is_hex, is_ledr, is_sw, is_kc, is_mmio;
    logic legal, misaligned, acc_err, commit;

    // Full 32-bit compare so nothing above the RAM aliases into it.
    assign in_ram  = (addr_q >> (AW + 2)) == 32'd0;
    assign is_hex  = addr_q == ADDR_HEX;
    assign is_ledr = addr_q == ADDR_LEDR;
    assign is_sw   = addr_q == ADDR_SW;
    assign is_kc   = addr_q == ADDR_KEYCAP;
    assign is_mmio = is_hex | is_ledr | is_sw | is_kc;

    assign legal      = ctrl_q inside {CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU};
    assign misaligned = ((ctrl_q == CTRL_H || ctrl_q == CTRL_HU) && addr_q[0]) ||
                        ((ctrl_q == CTRL_W) && (addr_q[1:0] != 2'b00));

    // MMIO registers only take whole-word accesses.
    assign acc_err = !legal || misaligned || !(in_ram || is_mmio) ||
                     (is_mmio && ctrl_q != CTRL_W);

    assign commit = (state_q == ST_ACCESS) && write_q && !acc_err;

    // ---------------- store lane steering ----------------
    logic [3:0]  be;
    logic [31:0] lane_wdata;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata_q;
        case (ctrl_q)
            CTRL_B, CTRL_BU: begin
                be         = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            CTRL_H, CTRL_HU: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            CTRL_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // ---------------- byte-enable block RAM (not reset) ----------------
    logic [3:0][7:0] ram_q [RAM_WORDS];
    logic [AW-1:0]   ram_idx;
    logic            ram_we;

    assign ram_idx = addr_q[AW+1:2];
    // A reset landing on the commit edge drops the store.
    assign ram_we  = commit && in_ram && reset_n;

    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we && be[i]) ram_q[ram_idx][i] <= lane_wdata[8*i +: 8];
            end
            ram_rdata_q <= ram_q[ram_idx];
        end
    end

    // ---------------- MMIO read mux ----------------
    logic [31:0] mmio_rd;

    always_comb begin
        mmio_rd = 32'h0;
        if (is_hex)  mmio_rd = {8'h00, hex_q};
        if (is_ledr) mmio_rd = {22'h0, ledr_q};
        if (is_sw)   mmio_rd = {22'h0, sw_s2_q};
        if (is_kc)   mmio_rd = {28'h0, keycap};
    end

    assign keycap_clr = (commit && is_kc) ? wdata_q[3:0] : 4'h0;

    key_capture u_keys (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_in   (key_in),
        .clr_i    (keycap_clr),
        .keycap_o (keycap)
    );

    // ---------------- sequential state ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            ctrl_q      <= 3'b000;
            err_q       <= 1'b0;
            is_ram_q    <= 1'b0;
            mmio_word_q <= 32'h0;
            hex_q       <= 24'h0;
            ledr_q      <= 10'h0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
        end else begin
            state_q <= state_d;
            sw_s1_q <= sw_in;
            sw_s2_q <= sw_s1_q;
            if (state_q == ST_IDLE && bus.req_valid) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                ctrl_q  <= bus.req_ctrl;
            end
            if (state_q == ST_ACCESS) begin
                err_q       <= acc_err;
                is_ram_q    <= in_ram;
                mmio_word_q <= mmio_rd;
            end
            if (commit && is_hex)  hex_q  <= wdata_q[23:0];
            if (commit && is_ledr) ledr_q <= wdata_q[9:0];
        end
    end

    // ---------------- FSM next state / handshake outputs ----------------
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = ST_ACCESS;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                // Everything feeding this is frozen until the handshake.
                if (!err_q && !write_q)
                    bus.resp_rdata = load_extend(is_ram_q ? ram_rdata_q : mmio_word_q,
                                                 addr_q[1:0], ctrl_q);
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hex_value = hex_q;
    assign ledr_out  = ledr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
    import bus_pkg::*;

    localparam int RW = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sw_in;
    logic [3:0]  key_in;
    logic [23:0] hex_value;
    logic [9:0]  ledr_out;

    data_bus_if bus();

    data_bus_responder #(.RAM_WORDS(RW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .sw_in     (sw_in),
        .key_in    (key_in),
        .hex_value (hex_value),
        .ledr_out  (ledr_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory is a flat byte array; loads/stores are assembled byte by byte.
    logic [7:0]  mem [RW*4];
    bit          model_ok = 0;
    bit          pending;      // a request has been accepted and not yet consumed
    int          m_age;        // edges since acceptance (0 = access not yet done)
    logic        m_w;
    logic [31:0] m_a, m_wd;
    logic [2:0]  m_c;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [23:0] m_hex;
    logic [9:0]  m_ledr;
    logic [3:0]  m_kc;
    logic [3:0]  kh1, kh2, kh3;   // key samples 1, 2, 3 edges ago
    logic [9:0]  sh1, sh2;        // switch samples 1, 2 edges ago
    int          sz;
    bit          is_mm, in_r, bad;
    logic [31:0] v;
    logic [3:0]  set_b, clr_b;

    function automatic int nbytes(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            model_ok = 1;
            pending  = 0;
            m_age    = 0;
            m_hex    = 24'h0;
            m_ledr   = 10'h0;
            m_kc     = 4'h0;
            m_rdata  = 32'h0;
            m_err    = 1'b0;
            kh1 = 4'hF; kh2 = 4'hF; kh3 = 4'hF;
            sh1 = 10'h0; sh2 = 10'h0;
        end else begin
            set_b = kh3 & ~kh2;   // synchronized key went 1 -> 0
            clr_b = 4'h0;
            if (pending && m_age == 0) begin
                sz    = nbytes(m_c);
                is_mm = (m_a >= ADDR_HEX) && (m_a <= ADDR_KEYCAP) && (m_a[1:0] == 2'b00);
                in_r  = m_a < 32'(RW*4);
                bad   = (sz == 0) || !(in_r || is_mm);
                if (!bad) bad = ((m_a % 32'(sz)) != 0) || (is_mm && sz != 4);
                v = 32'h0;
                if (!bad && in_r) begin
                    for (int i = 0; i < sz; i++) v[8*i +: 8] = mem[int'(m_a[9:0]) + i];
                    if (m_c == 3'b000) v = {{24{v[7]}}, v[7:0]};
                    if (m_c == 3'b001) v = {{16{v[15]}}, v[15:0]};
                end
                if (!bad && is_mm) begin
                    case (m_a[3:0])
                        4'h0:    v = {8'h0, m_hex};
                        4'h4:    v = {22'h0, m_ledr};
                        4'h8:    v = {22'h0, sh2};
                        default: v = {28'h0, m_kc};
                    endcase
                end
                m_err   = bad;
                m_rdata = (bad || m_w) ? 32'h0 : v;
                if (!bad && m_w) begin
                    if (in_r) begin
                        for (int i = 0; i < sz; i++) mem[int'(m_a[9:0]) + i] = m_wd[8*i +: 8];
                    end else begin
                        case (m_a[3:0])
                            4'h0:    m_hex  = m_wd[23:0];
                            4'h4:    m_ledr = m_wd[9:0];
                            4'hC:    clr_b  = m_wd[3:0];
                            default: ;
                        endcase
                    end
                end
                m_age = 1;
            end else if (pending && bus.resp_ready) begin
                pending = 0;
            end else if (!pending && bus.req_valid) begin
                pending = 1;
                m_age   = 0;
                m_w     = bus.req_write;
                m_a     = bus.req_addr;
                m_wd    = bus.req_wdata;
                m_c     = bus.req_ctrl;
            end
            m_kc = (m_kc & ~clr_b) | set_b;
            kh3 = kh2; kh2 = kh1; kh1 = key_in;
            sh2 = sh1; sh1 = sw_in;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit exp_valid;
    always @(negedge clk) begin
        if (model_ok) begin
            exp_valid = pending && (m_age == 1);
            chk("req_ready",  32'(bus.req_ready),  32'(!pending));
            chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
            chk("resp_rdata", bus.resp_rdata, exp_valid ? m_rdata : 32'h0);
            chk("resp_err",   32'(bus.resp_err),   32'(exp_valid && m_err));
            chk("hex_value",  32'(hex_value), 32'(m_hex));
            chk("ledr_out",   32'(ledr_out),  32'(m_ledr));
        end
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the handshake edge.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] c, output logic [31:0] rd, output logic e);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_ctrl  = c;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready && n < 10);
        chk("accept", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 10);
        chk("latency", 32'(n), 32'd2);
        rd = bus.resp_rdata;
        e  = bus.resp_err;
        @(posedge clk); #1;
    endtask

    task automatic ld(input logic [2:0] c, input logic [31:0] a, input logic [31:0] exp_rd,
                      input logic exp_e, input string name);
        logic [31:0] rd;
        logic        e;
        xact(1'b0, a, 32'h0, c, rd, e);
        chk(name, rd, exp_rd);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic st(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                      input logic exp_e, input string name);
        logic [31:0] rd;
        logic        e;
        xact(1'b1, a, wd, c, rd, e);
        chk(name, rd, 32'h0);
        chk({name, "_err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n        = 1'b0;
        sw_in          = 10'h155;
        key_in         = 4'hF;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_ctrl   = 3'b000;
        bus.resp_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hex",   32'(hex_value), 32'h0);
        chk("rst_ledr",  32'(ledr_out),  32'h0);
        chk("rst_valid", 32'(bus.resp_valid), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;

        // RAM lanes and extension
        st(CTRL_W,  32'h10, 32'hDEADBEEF, 1'b0, "sw_10");
        ld(CTRL_B,  32'h13, 32'hFFFFFFDE, 1'b0, "lb_13");
        ld(CTRL_BU, 32'h13, 32'h000000DE, 1'b0, "lbu_13");
        ld(CTRL_HU, 32'h10, 32'h0000BEEF, 1'b0, "lhu_10");
        ld(CTRL_W,  32'h10, 32'hDEADBEEF, 1'b0, "lw_10");
        ld(CTRL_H,  32'h12, 32'hFFFFDEAD, 1'b0, "lh_12");
        ld(CTRL_B,  32'h10, 32'hFFFFFFEF, 1'b0, "lb_10");

        // errors leave state alone
        st(CTRL_H,  32'h11, 32'h0000FFFF, 1'b1, "sh_misal");
        ld(CTRL_W,  32'h10, 32'hDEADBEEF, 1'b0, "lw_after_misal");
        ld(CTRL_W,  32'h2000_0000, 32'h0, 1'b1, "lw_unmapped");
        st(3'b011,  32'h10, 32'h0, 1'b1, "st_illegal_ctrl");
        ld(3'b110,  32'h10, 32'h0, 1'b1, "ld_illegal_ctrl");
        ld(CTRL_W,  32'h10, 32'hDEADBEEF, 1'b0, "lw_after_illegal");
        ld(CTRL_W,  32'h12, 32'h0, 1'b1, "lw_misal");

        // byte/halfword stores
        st(CTRL_B,  32'h11, 32'h0000A577, 1'b0, "sb_11");
        ld(CTRL_W,  32'h10, 32'hDEAD77EF, 1'b0, "lw_after_sb");
        st(CTRL_W,  32'h14, 32'h0, 1'b0, "sw_14");
        st(CTRL_H,  32'h16, 32'hABCD8001, 1'b0, "sh_16");
        ld(CTRL_W,  32'h14, 32'h80010000, 1'b0, "lw_after_sh");
        ld(CTRL_H,  32'h16, 32'hFFFF8001, 1'b0, "lh_16");

        // RAM boundary
        st(CTRL_W,  32'h3FC, 32'h01234567, 1'b0, "sw_last");
        ld(CTRL_W,  32'h3FC, 32'h01234567, 1'b0, "lw_last");
        ld(CTRL_W,  32'h400, 32'h0, 1'b1, "lw_past_ram");

        // MMIO
        st(CTRL_W,  ADDR_HEX, 32'h00ABCDEF, 1'b0, "sw_hex");
        chk("hex_lit", 32'(hex_value), 32'h00ABCDEF);
        st(CTRL_W,  ADDR_LEDR, 32'h000003FF, 1'b0, "sw_ledr");
        chk("ledr_lit", 32'(ledr_out), 32'h3FF);
        st(CTRL_B,  ADDR_HEX, 32'h11, 1'b1, "sb_hex");
        chk("hex_kept", 32'(hex_value), 32'h00ABCDEF);
        ld(CTRL_W,  ADDR_HEX, 32'h00ABCDEF, 1'b0, "lw_hex");
        ld(CTRL_W,  ADDR_LEDR, 32'h3FF, 1'b0, "lw_ledr");
        ld(CTRL_W,  ADDR_SW, 32'h155, 1'b0, "lw_sw");
        st(CTRL_W,  ADDR_SW, 32'hFFFFFFFF, 1'b0, "sw_sw");
        ld(CTRL_BU, ADDR_SW, 32'h0, 1'b1, "lbu_mmio");
        ld(CTRL_W,  32'h1000_0010, 32'h0, 1'b1, "lw_past_mmio");
        ld(CTRL_W,  32'h1000_0002, 32'h0, 1'b1, "lw_mmio_misal");

        // key capture
        key_in[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1 key_in = 4'hF;
        repeat (4) @(posedge clk); #1;
        ld(CTRL_W,  ADDR_KEYCAP, 32'h4, 1'b0, "keycap_set");
        st(CTRL_W,  ADDR_KEYCAP, 32'h4, 1'b0, "keycap_clr");
        ld(CTRL_W,  ADDR_KEYCAP, 32'h0, 1'b0, "keycap_cleared");
        // press lands on the clear's commit edge
        key_in[2] = 1'b0;
        @(posedge clk); #1;
        st(CTRL_W,  ADDR_KEYCAP, 32'h4, 1'b0, "keycap_clr_race");
        repeat (3) @(posedge clk);
        #1 key_in = 4'hF;
        repeat (4) @(posedge clk); #1;
        ld(CTRL_W,  ADDR_KEYCAP, 32'h4, 1'b0, "keycap_set_wins");

        // response stall
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_ctrl   = CTRL_W;
        @(negedge clk);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 10);
        chk("stall_first", bus.resp_rdata, 32'hDEAD77EF);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.resp_valid), 32'h1);
            chk("stall_rdata", bus.resp_rdata, 32'hDEAD77EF);
            chk("stall_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(posedge clk); #1;

        // back-to-back throughput
        acc_q.delete();
        bus.req_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("b2b_count", 32'(acc_q.size() >= 3), 32'h1);
        for (int i = 1; i < acc_q.size(); i++) chk("b2b_gap", 32'(acc_q[i] - acc_q[i-1]), 32'd3);

        // reset during ACCESS of a HEX store
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = ADDR_HEX;
        bus.req_wdata = 32'h00123456;
        bus.req_ctrl  = CTRL_W;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset_n       = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_hex",   32'(hex_value), 32'h0);
        chk("rst_mid_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        ld(CTRL_W, ADDR_HEX, 32'h0, 1'b0, "hex_after_rst");
        ld(CTRL_W, 32'h10, 32'hDEAD77EF, 1'b0, "ram_kept_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
